dtm_jtag_tap_multi: RTL and testbench

Parametrised JTAG TAP controller for the debug transport module. It generalises the single DTMCS/DMI TAP to a configurable IR length and NumChannels user data-register channels. Each channel gets per-channel qualified capture/shift/update strobes and its own TDO return, so DR logic no longer decodes the IR itself. It sits between the JTAG pins and the DTM's DTMCS, DMI and any additional user DRs.

---
 rtl/dtm_jtag_tap_multi_if.sv | 20 ++
 rtl/dtm_jtag_tap_multi.sv | 171 +++++++++++++++++
 tb/tb_dtm_jtag_tap_multi.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dtm_jtag_tap_multi_if.sv
// rtl/dtm_jtag_tap_multi_if.sv - user DR channel bundle between the TAP and its data registers
interface dtm_jtag_tap_multi_if #(
  parameter int unsigned NumChannels = 2
);
  logic [NumChannels-1:0] chan_select_o;
  logic [NumChannels-1:0] chan_capture_o;
  logic [NumChannels-1:0] chan_shift_o;
  logic [NumChannels-1:0] chan_update_o;
  logic [NumChannels-1:0] chan_tdo_i;

  modport master (
    output chan_select_o, chan_capture_o, chan_shift_o, chan_update_o,
    input  chan_tdo_i
  );

  modport slave (
    input  chan_select_o, chan_capture_o, chan_shift_o, chan_update_o,
    output chan_tdo_i
  );
endinterface

// File: rtl/dtm_jtag_tap_multi.sv
// rtl/dtm_jtag_tap_multi.sv - parametrised JTAG TAP with per-channel user DR strobes
module dtm_jtag_tap_multi #(
  parameter int unsigned IrLength       = 5,
  parameter logic [31:0] IdCodeValue    = 32'h00000001,
  parameter int unsigned NumChannels    = 2,
  parameter int unsigned ChanIrBase     = 'h10,
  parameter int unsigned IrCaptureValue = 'b00101
) (
  input  logic                tck_i,
  input  logic                trst_i,
  input  logic                tms_i,
  input  logic                td_i,
  output logic                td_o,
  output logic                tdo_oe_o,
  output logic                tdi_o,
  output logic                tlr_o,
  output logic [IrLength-1:0] ir_o,
  output logic [3:0]          tap_state_o,
  dtm_jtag_tap_multi_if.master chan
);

  if (IrLength < 2 || IrLength > 8) begin : g_bad_ir_length
    $error("IrLength must be 2..8");
  end
  if (NumChannels < 1 || NumChannels > 8) begin : g_bad_num_channels
    $error("NumChannels must be 1..8");
  end
  if (IdCodeValue[0] != 1'b1) begin : g_bad_idcode
    $error("IdCodeValue bit 0 must be 1");
  end
  if ((IrCaptureValue % 4) != 1 || IrCaptureValue >= (1 << IrLength)) begin : g_bad_ir_capture
    $error("IrCaptureValue must fit IrLength and end in 2'b01");
  end
  if (ChanIrBase < 2 || ChanIrBase + NumChannels > (1 << IrLength) - 1) begin : g_bad_chan_base
    $error("channel IR codes must avoid 0, 1 and all-ones");
  end

  typedef enum logic [3:0] {
    TestLogicReset = 4'd0,
    RunTestIdle    = 4'd1,
    SelectDrScan   = 4'd2,
    CaptureDr      = 4'd3,
    ShiftDr        = 4'd4,
    Exit1Dr        = 4'd5,
    PauseDr        = 4'd6,
    Exit2Dr        = 4'd7,
    UpdateDr       = 4'd8,
    SelectIrScan   = 4'd9,
    CaptureIr      = 4'd10,
    ShiftIr        = 4'd11,
    Exit1Ir        = 4'd12,
    PauseIr        = 4'd13,
    Exit2Ir        = 4'd14,
    UpdateIr       = 4'd15
  } tap_state_e;

  localparam logic [IrLength-1:0] IrIdcode  = IrLength'(1);
  localparam logic [IrLength-1:0] IrCapture = IrLength'(IrCaptureValue);

  tap_state_e             state_q, state_d;
  logic [IrLength-1:0]    ir_q;
  logic [IrLength-1:0]    ir_sh_q;
  logic [31:0]            idcode_q;
  logic                   bypass_q;
  logic                   td_q;
  logic                   tdo_oe_q;
  logic                   tdo_d;

  logic [31:0]            ir_ext;
  logic                   ir_special;
  logic                   sel_idcode;
  logic                   sel_bypass;
  logic [NumChannels-1:0] chan_hit;
  logic [NumChannels-1:0] chan_sel;

  // IR decode: reserved codes win over the channel window, leftovers fall to bypass
  assign ir_ext     = 32'(ir_q);
  assign ir_special = ~|ir_q | &ir_q;
  assign sel_idcode = ~ir_special & (ir_q == IrIdcode);

  for (genvar k = 0; k < NumChannels; k++) begin : g_chan_decode
    assign chan_hit[k] = (ir_ext == ChanIrBase + k);
  end

  assign chan_sel   = (ir_special | sel_idcode) ? '0 : chan_hit;
  assign sel_bypass = ~sel_idcode & ~|chan_sel;

  assign chan.chan_select_o  = chan_sel;
  assign chan.chan_capture_o = (state_q == CaptureDr) ? chan_sel : '0;
  assign chan.chan_shift_o   = (state_q == ShiftDr)   ? chan_sel : '0;
  assign chan.chan_update_o  = (state_q == UpdateDr)  ? chan_sel : '0;

  assign td_o        = td_q;
  assign tdo_oe_o    = tdo_oe_q;
  assign tdi_o       = td_i;
  assign tlr_o       = (state_q == TestLogicReset);
  assign ir_o        = ir_q;
  assign tap_state_o = state_q;

  always_comb begin
    tdo_d = bypass_q;
    if (state_q == ShiftIr) begin
      tdo_d = ir_sh_q[0];
    end else if (sel_idcode) begin
      tdo_d = idcode_q[0];
    end else if (|chan_sel) begin
      tdo_d = |(chan_sel & chan.chan_tdo_i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  // Pause and Exit states fall through the case untouched, so every scan register holds
  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      state_q  <= TestLogicReset;
      ir_q     <= IrIdcode;
      ir_sh_q  <= '0;
      idcode_q <= IdCodeValue;
      bypass_q <= 1'b0;
      td_q     <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      td_q     <= tdo_d;
      tdo_oe_q <= (state_q == ShiftIr) | (state_q == ShiftDr);
      case (state_q)
        TestLogicReset: begin
          ir_q     <= IrIdcode;
          ir_sh_q  <= '0;
          idcode_q <= IdCodeValue;
          bypass_q <= 1'b0;
        end
        CaptureIr: ir_sh_q <= IrCapture;
        ShiftIr:   ir_sh_q <= {td_i, ir_sh_q[IrLength-1:1]};
        UpdateIr:  ir_q    <= ir_sh_q;
        CaptureDr: begin
          if (sel_idcode) idcode_q <= IdCodeValue;
          if (sel_bypass) bypass_q <= 1'b0;
        end
        ShiftDr: begin
          if (sel_idcode) idcode_q <= {td_i, idcode_q[31:1]};
          if (sel_bypass) bypass_q <= td_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dtm_jtag_tap_multi.sv
// tb/tb_dtm_jtag_tap_multi.sv - vector table and TDO scoreboard bench for dtm_jtag_tap_multi
module tb_dtm_jtag_tap_multi;

  localparam logic [31:0] IdCode = 32'h149511C3;

  logic       tck = 1'b0;
  logic       trst_i = 1'b1;
  logic       tms_i = 1'b1;
  logic       td_i = 1'b0;
  logic       td_o, tdo_oe_o, tdi_o, tlr_o;
  logic [4:0] ir_o;
  logic [3:0] tap_state_o;

  int         total = 0;
  int         bad = 0;
  logic       exp_q[$];
  logic [4:0] ir_cap = 5'b00101;

  dtm_jtag_tap_multi_if #(.NumChannels(2)) bus ();

  dtm_jtag_tap_multi #(
    .IrLength(5), .IdCodeValue(IdCode), .NumChannels(2),
    .ChanIrBase('h10), .IrCaptureValue('b00101)
  ) dut (
    .tck_i(tck), .trst_i(trst_i), .tms_i(tms_i), .td_i(td_i),
    .td_o(td_o), .tdo_oe_o(tdo_oe_o), .tdi_o(tdi_o), .tlr_o(tlr_o),
    .ir_o(ir_o), .tap_state_o(tap_state_o), .chan(bus)
  );

  always #5 tck = ~tck;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       tms, tdi;
    logic [1:0] ctdo;
    logic       push, pbit;
    logic [3:0] st;
    logic [4:0] ir;
    logic [1:0] sel, cap, sft, upd;
    logic       oe;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic tms, input logic tdi, input logic [1:0] ctdo,
                              input logic push, input logic pbit, input logic [3:0] st,
                              input logic [4:0] ir, input logic [1:0] sel, input logic [1:0] cap,
                              input logic [1:0] sft, input logic [1:0] upd, input logic oe);
    vec_t v;
    v.tms = tms; v.tdi = tdi; v.ctdo = ctdo; v.push = push; v.pbit = pbit;
    v.st = st; v.ir = ir; v.sel = sel; v.cap = cap; v.sft = sft; v.upd = upd; v.oe = oe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // TDO is popped against the scoreboard whenever the DUT flags a shifted bit
  task automatic step(input logic tms, input logic tdi);
    logic e;
    @(negedge tck);
    tms_i = tms;
    td_i  = tdi;
    @(posedge tck);
    #1;
    if (tdo_oe_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: td_o=%b with no expected bit queued", td_o);
      end else begin
        e = exp_q.pop_front();
        chk("sb_tdo", td_o, e);
      end
    end
  endtask

  task automatic shift_ir(input logic [4:0] val);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ir_cap[i]);
      step(i == 4, val[i]);
    end
    step(1, 0); step(0, 0);
    chk("ir_load", ir_o, val);
  endtask

  task automatic shift_dr(input int n, input logic [63:0] din, input logic [63:0] dexp,
                          input int pause_at);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(dexp[i]);
      step((i == n - 1) || (i == pause_at), din[i]);
      chk("dr_oe", tdo_oe_o, 1);
      if (i == pause_at) begin
        for (int p = 0; p < 3; p++) begin
          step(0, 0);
          chk("pause_state", tap_state_o, 6);
          chk("pause_strobes", {bus.chan_capture_o, bus.chan_shift_o, bus.chan_update_o}, 0);
        end
        step(1, 0);
        step(0, 0);
        chk("resume_state", tap_state_o, 4);
      end
    end
    step(1, 0); step(0, 0);
  endtask

  initial begin
    logic [63:0] din;
    bus.chan_tdo_i = 2'b00;

    step(1, 0);
    chk("rst_state", tap_state_o, 0);
    chk("rst_ir", ir_o, 1);
    chk("rst_tlr", tlr_o, 1);
    chk("rst_td", td_o, 0);
    chk("rst_oe", tdo_oe_o, 0);
    chk("rst_sel", bus.chan_select_o, 0);
    trst_i = 1'b0;
    step(0, 0);
    chk("rti_state", tap_state_o, 1);
    chk("rti_tlr", tlr_o, 0);
    chk("rti_ir", ir_o, 1);

    // IR load of 5'h11 then one DR scan on channel 1
    vt.push_back(mk(1, 0, 2'b00, 0, 0,  2, 5'h01, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    vt.push_back(mk(1, 0, 2'b00, 0, 0,  9, 5'h01, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    vt.push_back(mk(0, 0, 2'b00, 0, 0, 10, 5'h01, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    vt.push_back(mk(0, 0, 2'b00, 0, 0, 11, 5'h01, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    vt.push_back(mk(0, 1, 2'b00, 1, 1, 11, 5'h01, 2'b00, 2'b00, 2'b00, 2'b00, 1));
    vt.push_back(mk(0, 0, 2'b00, 1, 0, 11, 5'h01, 2'b00, 2'b00, 2'b00, 2'b00, 1));
    vt.push_back(mk(0, 0, 2'b00, 1, 1, 11, 5'h01, 2'b00, 2'b00, 2'b00, 2'b00, 1));
    vt.push_back(mk(0, 0, 2'b00, 1, 0, 11, 5'h01, 2'b00, 2'b00, 2'b00, 2'b00, 1));
    vt.push_back(mk(1, 1, 2'b00, 1, 0, 12, 5'h01, 2'b00, 2'b00, 2'b00, 2'b00, 1));
    vt.push_back(mk(1, 0, 2'b00, 0, 0, 15, 5'h01, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    vt.push_back(mk(0, 0, 2'b00, 0, 0,  1, 5'h11, 2'b10, 2'b00, 2'b00, 2'b00, 0));
    vt.push_back(mk(1, 0, 2'b00, 0, 0,  2, 5'h11, 2'b10, 2'b00, 2'b00, 2'b00, 0));
    vt.push_back(mk(0, 0, 2'b00, 0, 0,  3, 5'h11, 2'b10, 2'b10, 2'b00, 2'b00, 0));
    vt.push_back(mk(0, 0, 2'b00, 0, 0,  4, 5'h11, 2'b10, 2'b00, 2'b10, 2'b00, 0));
    vt.push_back(mk(0, 0, 2'b10, 1, 1,  4, 5'h11, 2'b10, 2'b00, 2'b10, 2'b00, 1));
    vt.push_back(mk(1, 0, 2'b01, 1, 0,  5, 5'h11, 2'b10, 2'b00, 2'b00, 2'b00, 1));
    vt.push_back(mk(1, 0, 2'b00, 0, 0,  8, 5'h11, 2'b10, 2'b00, 2'b00, 2'b10, 0));
    vt.push_back(mk(0, 0, 2'b00, 0, 0,  1, 5'h11, 2'b10, 2'b00, 2'b00, 2'b00, 0));

    foreach (vt[i]) begin
      bus.chan_tdo_i = vt[i].ctdo;
      if (vt[i].push) exp_q.push_back(vt[i].pbit);
      step(vt[i].tms, vt[i].tdi);
      chk($sformatf("tbl%0d_state", i), tap_state_o, vt[i].st);
      chk($sformatf("tbl%0d_ir", i), ir_o, vt[i].ir);
      chk($sformatf("tbl%0d_sel", i), bus.chan_select_o, vt[i].sel);
      chk($sformatf("tbl%0d_cap", i), bus.chan_capture_o, vt[i].cap);
      chk($sformatf("tbl%0d_sft", i), bus.chan_shift_o, vt[i].sft);
      chk($sformatf("tbl%0d_upd", i), bus.chan_update_o, vt[i].upd);
      chk($sformatf("tbl%0d_oe", i), tdo_oe_o, vt[i].oe);
      chk($sformatf("tbl%0d_tdi", i), tdi_o, vt[i].tdi);
    end
    bus.chan_tdo_i = 2'b00;

    // Unassigned IR code falls to bypass
    shift_ir(5'h07);
    chk("byp_sel", bus.chan_select_o, 0);
    shift_dr(4, 64'b1101, 64'b1010, -1);

    // IDCODE shifted out with a three-cycle pause in the middle
    trst_i = 1'b1;
    step(1, 0);
    trst_i = 1'b0;
    chk("id_rst_state", tap_state_o, 0);
    step(0, 0);
    din = {$urandom, $urandom};
    shift_dr(40, din, {din[31:0], IdCode}, 10);

    // Channel 0 scan with pause, aborted by trst mid-shift
    shift_ir(5'h10);
    chk("ch0_sel", bus.chan_select_o, 2'b01);
    step(1, 0);
    step(0, 0);
    chk("ch0_cap", bus.chan_capture_o, 2'b01);
    step(0, 0);
    chk("ch0_sft", bus.chan_shift_o, 2'b01);
    bus.chan_tdo_i = 2'b01; exp_q.push_back(1'b1); step(0, 0);
    bus.chan_tdo_i = 2'b10; exp_q.push_back(1'b0); step(1, 0);
    chk("ch0_exit1", tap_state_o, 5);
    step(0, 0);
    chk("ch0_pause_sft", bus.chan_shift_o, 0);
    chk("ch0_pause_upd", bus.chan_update_o, 0);
    chk("ch0_pause_sel", bus.chan_select_o, 2'b01);
    step(1, 0);
    step(0, 0);
    chk("ch0_resume_sft", bus.chan_shift_o, 2'b01);
    bus.chan_tdo_i = 2'b01; exp_q.push_back(1'b1); step(0, 0);
    trst_i = 1'b1;
    step(1, 0);
    trst_i = 1'b0;
    chk("abort_state", tap_state_o, 0);
    chk("abort_ir", ir_o, 1);
    chk("abort_upd", bus.chan_update_o, 0);
    chk("abort_oe", tdo_oe_o, 0);
    chk("abort_td", td_o, 0);
    step(1, 0);
    chk("abort_hold_state", tap_state_o, 0);
    chk("abort_hold_upd", bus.chan_update_o, 0);
    bus.chan_tdo_i = 2'b00;

    // Five TMS=1 cycles out of ShiftIr pass through UpdateIr then reset
    step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    chk("tms5_shiftir", tap_state_o, 11);
    exp_q.push_back(ir_cap[0]);
    step(1, 0); step(1, 0); step(1, 0);
    chk("tms5_ir_upd", ir_o, 2);
    step(1, 0); step(1, 0);
    chk("tms5_state", tap_state_o, 0);
    chk("tms5_tlr", tlr_o, 1);
    step(1, 0);
    chk("tms5_ir", ir_o, 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
